// File: rtl/matmul_tile_engine_if.sv
// rtl/matmul_tile_engine_if.sv - control, SRAM read and O-write signals of the matmul tile engine
interface matmul_tile_engine_if #(
  parameter int ARR = 4,
  parameter int DW  = 8,
  parameter int OW  = 16,
  parameter int KW  = 4
);
  localparam int MW  = $clog2(ARR) + 1;
  localparam int AOW = $clog2(ARR);

  logic              START;
  logic [MW-1:0]     M;
  logic [MW-1:0]     N;
  logic [KW-1:0]     K;
  logic              SIGNED;
  logic              ACCUM;
  logic              BUSY;
  logic              DONE;
  logic              EN_I;
  logic [KW-2:0]     ADDR_I;
  logic [ARR*DW-1:0] RDATA_I;
  logic              EN_W;
  logic [KW-2:0]     ADDR_W;
  logic [ARR*DW-1:0] RDATA_W;
  logic              EN_O;
  logic              RW_O;
  logic [AOW-1:0]    ADDR_O;
  logic [ARR*OW-1:0] WDATA_O;

  modport master (
    input  START, M, N, K, SIGNED, ACCUM, RDATA_I, RDATA_W,
    output BUSY, DONE, EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O, WDATA_O
  );

  modport slave (
    output START, M, N, K, SIGNED, ACCUM, RDATA_I, RDATA_W,
    input  BUSY, DONE, EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O, WDATA_O
  );
endinterface

// File: rtl/matmul_tile_engine.sv
// rtl/matmul_tile_engine.sv - ARR x ARR outer-product MAC array computing one O = I * W tile
module matmul_tile_engine #(
  parameter int ARR  = 4,
  parameter int DW   = 8,
  parameter int OW   = 16,
  parameter int KMAX = 8,
  parameter int KW   = 4,
  parameter int AW   = 2*DW + KW
) (
  input  logic CLK,
  input  logic RSTN,
  matmul_tile_engine_if.master bus
);
  localparam int MW  = $clog2(ARR) + 1;
  localparam int AOW = $clog2(ARR);
  localparam int PW  = 2*DW + 2;

  localparam logic signed [AW-1:0] SMAX = AW'((1 << (OW-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic signed [AW-1:0] UMAX = AW'((1 << OW) - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, WRITE, FIN} state_t;

  state_t            state;
  logic [MW-1:0]     m_r, n_r, rc;
  logic [KW-1:0]     k_r, kc;
  logic              sgn_r;
  logic              rd_valid;
  logic              busy, done, en_rd, en_o;
  logic [KW-2:0]     addr_rd;
  logic [AOW-1:0]    addr_o;
  logic [ARR*OW-1:0] wdata;

  logic signed [AW-1:0] acc     [ARR][ARR];
  logic signed [AW-1:0] acc_nxt [ARR][ARR];

  logic [MW-1:0]     m_eff, n_eff;
  logic [KW-1:0]     k_eff;
  logic              start_ok;
  logic [AOW-1:0]    row_sel;
  logic [ARR*OW-1:0] row_data;

  function automatic logic [OW-1:0] sat(input logic signed [AW-1:0] v, input logic s);
    logic [OW-1:0] r;
    if (s) begin
      if (v > SMAX)      r = SMAX[OW-1:0];
      else if (v < SMIN) r = SMIN[OW-1:0];
      else               r = v[OW-1:0];
    end else begin
      if (v[AW-1])       r = '0;
      else if (v > UMAX) r = '1;
      else               r = v[OW-1:0];
    end
    return r;
  endfunction

  assign start_ok = (state == IDLE) && bus.START;

  always_comb begin
    m_eff = bus.M;
    if (bus.M == '0) m_eff = MW'(1);
    else if (bus.M > MW'(ARR)) m_eff = MW'(ARR);
    n_eff = bus.N;
    if (bus.N == '0) n_eff = MW'(1);
    else if (bus.N > MW'(ARR)) n_eff = MW'(ARR);
    k_eff = (bus.K > KW'(KMAX)) ? KW'(KMAX) : bus.K;
  end

  // Every cell accumulates, masked or not, so the datapath never depends on M/N.
  always_comb begin
    logic signed [DW:0]   a;
    logic signed [DW:0]   b;
    logic signed [PW-1:0] p;
    a = '0;
    b = '0;
    p = '0;
    for (int i = 0; i < ARR; i++) begin
      for (int j = 0; j < ARR; j++) begin
        a = {sgn_r & bus.RDATA_I[i*DW+DW-1], bus.RDATA_I[i*DW +: DW]};
        b = {sgn_r & bus.RDATA_W[j*DW+DW-1], bus.RDATA_W[j*DW +: DW]};
        p = a * b;
        acc_nxt[i][j] = acc[i][j];
        if (start_ok && !bus.ACCUM)
          acc_nxt[i][j] = '0;
        else if (rd_valid)
          acc_nxt[i][j] = acc[i][j] + {{(AW-PW){p[PW-1]}}, p};
      end
    end
  end

  // Row 0 is formed on the same edge as the last accumulation, hence acc_nxt.
  always_comb begin
    row_sel  = (state == LAST) ? '0 : rc[AOW-1:0];
    row_data = '0;
    for (int j = 0; j < ARR; j++)
      if (MW'(j) < n_r)
        row_data[j*OW +: OW] = sat(acc_nxt[row_sel][j], sgn_r);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < ARR; i++)
        for (int j = 0; j < ARR; j++)
          acc[i][j] <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      m_r      <= MW'(1);
      n_r      <= MW'(1);
      k_r      <= '0;
      kc       <= '0;
      rc       <= '0;
      sgn_r    <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      en_rd    <= 1'b0;
      addr_rd  <= '0;
      en_o     <= 1'b0;
      addr_o   <= '0;
      wdata    <= '0;
    end else begin
      rd_valid <= en_rd;
      case (state)
        IDLE: begin
          if (bus.START) begin
            m_r   <= m_eff;
            n_r   <= n_eff;
            k_r   <= k_eff;
            sgn_r <= bus.SIGNED;
            busy  <= 1'b1;
            if (k_eff == '0) begin
              state <= LAST;
            end else begin
              state   <= FETCH;
              en_rd   <= 1'b1;
              addr_rd <= '0;
              kc      <= KW'(1);
            end
          end
        end
        FETCH: begin
          if (kc == k_r) begin
            state   <= LAST;
            en_rd   <= 1'b0;
            addr_rd <= '0;
          end else begin
            addr_rd <= kc[KW-2:0];
            kc      <= kc + KW'(1);
          end
        end
        LAST: begin
          state  <= WRITE;
          en_o   <= 1'b1;
          addr_o <= '0;
          wdata  <= row_data;
          rc     <= MW'(1);
        end
        WRITE: begin
          if (rc == m_r) begin
            state  <= FIN;
            en_o   <= 1'b0;
            addr_o <= '0;
            wdata  <= '0;
            done   <= 1'b1;
          end else begin
            addr_o <= rc[AOW-1:0];
            wdata  <= row_data;
            rc     <= rc + MW'(1);
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.EN_I    = en_rd;
  assign bus.EN_W    = en_rd;
  assign bus.ADDR_I  = addr_rd;
  assign bus.ADDR_W  = addr_rd;
  assign bus.EN_O    = en_o;
  assign bus.RW_O    = 1'b1;
  assign bus.ADDR_O  = addr_o;
  assign bus.WDATA_O = wdata;
endmodule

// File: tb/tb_matmul_tile_engine.sv
// tb/tb_matmul_tile_engine.sv - bench for matmul_tile_engine
module tb_matmul_tile_engine;
  localparam int ARR = 4, DW = 8, OW = 16, KMAX = 8, KW = 4;
  localparam int MW = $clog2(ARR) + 1, AOW = $clog2(ARR);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  matmul_tile_engine_if #(.ARR(ARR), .DW(DW), .OW(OW), .KW(KW)) bus();
  matmul_tile_engine #(.ARR(ARR), .DW(DW), .OW(OW), .KMAX(KMAX), .KW(KW)) dut (
    .CLK(clk), .RSTN(rstn), .bus(bus));

  typedef struct {
    int m, n, k;
    bit sgn, acc;
    int mode;
    logic [7:0] iv, wv;
    int koff, lat, writes;
    bit chk;
    logic [ARR*OW-1:0] row0;
  } vec_t;

  typedef struct {
    logic [AOW-1:0] addr;
    logic [ARR*OW-1:0] data;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];
  logic [ARR*DW-1:0] mem_i[KMAX], mem_w[KMAX], big_i[16], big_w[16];
  logic [ARR*OW-1:0] cap[12][ARR];
  longint macc[ARR][ARR];
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, writes = 0;
  int sedge = 0, done_base = 0, wr_base = 0, cur_vec = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint ext(input logic [7:0] x, input bit s);
    return s ? longint'(signed'(x)) : longint'({56'd0, x});
  endfunction

  function automatic logic [15:0] msat(input longint v, input bit s);
    if (s) begin
      if (v > 32767) return 16'h7fff;
      if (v < -32768) return 16'h8000;
    end else begin
      if (v < 0) return 16'h0000;
      if (v > 65535) return 16'hffff;
    end
    return v[15:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.EN_I) bus.RDATA_I <= mem_i[bus.ADDR_I];
    if (bus.EN_W) bus.RDATA_W <= mem_w[bus.ADDR_W];
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.EN_O) begin
        writes++;
        cap[cur_vec][bus.ADDR_O] = bus.WDATA_O;
        chk("rw_o", bus.RW_O, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("addr_o", bus.ADDR_O, e.addr);
          chk("wdata_o", bus.WDATA_O, e.data);
        end
      end
      if (bus.DONE) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", bus.BUSY, 1);
      end
    end
  end

  task automatic fill_and_model(input vec_t v);
    int meff, neff, keff;
    exp_t e;
    for (int k = 0; k < KMAX; k++) begin
      for (int l = 0; l < ARR; l++) begin
        case (v.mode)
          0: begin mem_i[k] = big_i[k+v.koff]; mem_w[k] = big_w[k+v.koff]; end
          1: begin mem_i[k][l*DW +: DW] = v.iv; mem_w[k][l*DW +: DW] = v.wv; end
          default: begin
            mem_i[k][l*DW +: DW] = 8'(4*l + k);
            mem_w[k][l*DW +: DW] = (l == k) ? 8'd1 : 8'd0;
          end
        endcase
      end
    end
    meff = (v.m == 0) ? 1 : (v.m > ARR ? ARR : v.m);
    neff = (v.n == 0) ? 1 : (v.n > ARR ? ARR : v.n);
    keff = (v.k > KMAX) ? KMAX : v.k;
    if (!v.acc)
      for (int i = 0; i < ARR; i++) for (int j = 0; j < ARR; j++) macc[i][j] = 0;
    for (int k = 0; k < keff; k++)
      for (int i = 0; i < ARR; i++)
        for (int j = 0; j < ARR; j++)
          macc[i][j] += ext(mem_i[k][i*DW +: DW], v.sgn) * ext(mem_w[k][j*DW +: DW], v.sgn);
    for (int i = 0; i < meff; i++) begin
      e.addr = AOW'(i);
      e.data = '0;
      for (int j = 0; j < neff; j++) e.data[j*OW +: OW] = msat(macc[i][j], v.sgn);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_run(input int vi);
    vec_t v;
    v = vecs[vi];
    fill_and_model(v);
    cur_vec = vi;
    @(negedge clk);
    bus.START = 1'b1;
    bus.M = MW'(v.m);
    bus.N = MW'(v.n);
    bus.K = KW'(v.k);
    bus.SIGNED = v.sgn;
    bus.ACCUM = v.acc;
    done_base = done_cnt;
    wr_base = writes;
    @(posedge clk); #1;
    sedge = cyc;
    bus.START = 1'b0;
    chk("busy_after_start", bus.BUSY, 1);
  endtask

  task automatic finish_run(input int vi);
    vec_t v;
    int w;
    v = vecs[vi];
    w = 0;
    while (done_cnt == done_base && w < 200) begin
      @(negedge clk); #1;
      w++;
    end
    if (done_cnt == done_base) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_latency", 64'(done_cyc - sedge + 1), 64'(v.lat));
      chk("write_count", 64'(writes - wr_base), 64'(v.writes));
      chk("queue_empty", 64'(exp_q.size()), 0);
      if (v.chk) chk("row0_literal", cap[vi][0], v.row0);
      @(negedge clk); #1;
      chk("busy_after_done", bus.BUSY, 0);
      chk("done_pulse_once", 64'(done_cnt - done_base), 1);
    end
  endtask

  task automatic run_vec(input int vi);
    start_run(vi);
    finish_run(vi);
  endtask

  initial begin
    int db;
    vecs[0]  = '{4, 4, 4,  0, 0, 2, 8'h00, 8'h00, 0, 10, 4, 1, 64'h0003_0002_0001_0000};
    vecs[1]  = '{4, 4, 4,  1, 0, 1, 8'h80, 8'h7f, 0, 10, 4, 1, 64'h8000_8000_8000_8000};
    vecs[2]  = '{4, 4, 4,  0, 0, 1, 8'hff, 8'hff, 0, 10, 4, 1, 64'hffff_ffff_ffff_ffff};
    vecs[3]  = '{2, 3, 1,  0, 0, 1, 8'h01, 8'h01, 0,  5, 2, 1, 64'h0000_0001_0001_0001};
    vecs[4]  = '{4, 4, 4,  1, 0, 0, 8'h00, 8'h00, 0, 10, 4, 0, 64'h0};
    vecs[5]  = '{4, 4, 2,  1, 0, 0, 8'h00, 8'h00, 0,  8, 4, 0, 64'h0};
    vecs[6]  = '{4, 4, 2,  1, 1, 0, 8'h00, 8'h00, 2,  8, 4, 0, 64'h0};
    vecs[7]  = '{4, 4, 0,  1, 1, 0, 8'h00, 8'h00, 0,  6, 4, 0, 64'h0};
    vecs[8]  = '{0, 0, 3,  0, 0, 1, 8'h03, 8'h05, 0,  6, 1, 1, 64'h0000_0000_0000_002d};
    vecs[9]  = '{3, 4, 15, 0, 0, 0, 8'h00, 8'h00, 0, 13, 3, 0, 64'h0};
    vecs[10] = '{4, 2, 4,  1, 0, 1, 8'h80, 8'h80, 0, 10, 4, 1, 64'h0000_0000_7fff_7fff};
    vecs[11] = '{4, 4, 4,  0, 0, 1, 8'h02, 8'h03, 0, 10, 4, 1, 64'h0018_0018_0018_0018};
    for (int k = 0; k < 16; k++) begin
      big_i[k] = $urandom;
      big_w[k] = $urandom;
    end
    for (int i = 0; i < ARR; i++) for (int j = 0; j < ARR; j++) macc[i][j] = 0;
    bus.START = 1'b0; bus.M = '0; bus.N = '0; bus.K = '0;
    bus.SIGNED = 1'b0; bus.ACCUM = 1'b0;
    bus.RDATA_I = '0; bus.RDATA_W = '0;

    @(posedge clk); #1;
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_en_i", bus.EN_I, 0);
    chk("rst_en_w", bus.EN_W, 0);
    chk("rst_en_o", bus.EN_O, 0);
    chk("rst_addr", {bus.ADDR_I, bus.ADDR_W, bus.ADDR_O}, 0);
    chk("rst_wdata", bus.WDATA_O, 0);
    chk("rst_rw_o", bus.RW_O, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int vi = 0; vi < 11; vi++) run_vec(vi);
    for (int r = 0; r < ARR; r++) begin
      chk("ksplit_eq_full", cap[6][r], cap[4][r]);
      chk("k0_reemit", cap[7][r], cap[6][r]);
    end

    start_run(11);
    for (int k = 0; k < 4; k++) begin
      chk("fetch_en", {bus.EN_I, bus.EN_W}, 2'b11);
      chk("fetch_addr_i", bus.ADDR_I, k);
      chk("fetch_addr_w", bus.ADDR_W, k);
      if (k == 1) begin
        bus.START = 1'b1; bus.M = MW'(1); bus.K = '0; bus.ACCUM = 1'b1;
      end
      if (k == 2) bus.START = 1'b0;
      @(posedge clk); #1;
    end
    finish_run(11);
    repeat (12) @(negedge clk);
    chk("glitch_single_done", 64'(done_cnt - done_base), 1);

    start_run(11);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("midrst_busy", bus.BUSY, 0);
    chk("midrst_en", {bus.EN_I, bus.EN_W, bus.EN_O, bus.DONE}, 0);
    chk("midrst_addr", {bus.ADDR_I, bus.ADDR_W, bus.ADDR_O}, 0);
    chk("midrst_wdata", bus.WDATA_O, 0);
    exp_q.delete();
    for (int i = 0; i < ARR; i++) for (int j = 0; j < ARR; j++) macc[i][j] = 0;
    @(negedge clk);
    rstn = 1'b1;
    db = done_cnt;
    repeat (15) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - db), 0);
    run_vec(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
